// File: rtl/ipd_sequencer.sv
// Purpose: sample-rate sequencer for the servo I-PD loop (tick, measure, step, settle, clamp to PWM duty).
// Latency: meas_req one cycle after the tick; duty/duty_valid 3+SETTLE cycles after the accepted meas_ack.
// Backpressure: meas_req is held until meas_ack or TIMEOUT (then sticky fault); a tick during a busy sample sets overrun and is dropped.
module ipd_sequencer #(
    parameter int Magnitud = 17,
    parameter int Decimal  = 0,
    parameter int N        = Magnitud + Decimal + 1,
    parameter int W        = 10,
    parameter int DUTY_MAX = 1000,
    parameter int PERIOD   = 50000,
    parameter int SETTLE   = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic signed [N-1:0] ref_in,
    output logic                meas_req,
    input  logic                meas_ack,
    input  logic signed [N-1:0] meas_data,
    output logic signed [N-1:0] referencia,
    output logic signed [N-1:0] y,
    output logic                enable,
    output logic                pid_clear,
    input  logic signed [N-1:0] IPD,
    output logic [W-1:0]        duty,
    output logic                duty_valid,
    output logic                busy,
    output logic                fault,
    output logic                overrun
);

    localparam int CW = (PERIOD  > 1) ? $clog2(PERIOD)      : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW = (SETTLE  > 0) ? $clog2(SETTLE + 1)  : 1;
    localparam logic signed [N-1:0] DMAX_S = N'(DUTY_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_REQ,
        S_STEP,
        S_SETTLE,
        S_UPDATE
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         tick_cnt_q;
    logic [TW-1:0]         tmo_cnt_q;
    logic [SW-1:0]         settle_cnt_q;
    logic                  meas_req_q;
    logic                  enable_q;
    logic                  pid_clear_q;
    logic                  duty_valid_q;
    logic                  busy_q;
    logic                  fault_q;
    logic                  overrun_q;
    logic [W-1:0]          duty_q;
    logic signed [N-1:0]   referencia_q;
    logic signed [N-1:0]   y_q;

    logic                  tick;
    logic signed [N-1:0]   s_val;
    logic [W-1:0]          duty_d;

    // Sample tick: last count of the period; the counter is parked at 0 while IDLE.
    assign tick  = (state_q != S_IDLE) && (tick_cnt_q == CW'(PERIOD - 1));
    assign s_val = IPD >>> Decimal;

    // Scale the controller output to integer units and clamp to [0, DUTY_MAX].
    always_comb begin
        duty_d = '0;
        if (s_val < 0) begin
            duty_d = '0;
        end else if (s_val > DMAX_S) begin
            duty_d = W'(DUTY_MAX);
        end else begin
            duty_d = s_val[W-1:0];
        end
    end

    // Sequencer FSM with period/timeout/settle counters and all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            settle_cnt_q <= '0;
            meas_req_q   <= 1'b0;
            enable_q     <= 1'b0;
            pid_clear_q  <= 1'b1;
            duty_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            overrun_q    <= 1'b0;
            duty_q       <= '0;
            referencia_q <= '0;
            y_q          <= '0;
        end else if (!run) begin
            // Loop stopped: abandon any sample, park in IDLE and clear sticky flags.
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            settle_cnt_q <= '0;
            meas_req_q   <= 1'b0;
            enable_q     <= 1'b0;
            pid_clear_q  <= 1'b1;
            duty_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            overrun_q    <= 1'b0;
            duty_q       <= '0;
        end else begin
            enable_q     <= 1'b0;
            duty_valid_q <= 1'b0;

            if (state_q == S_IDLE || tick) begin
                tick_cnt_q <= '0;
            end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
            end

            // A tick while a sample is still in flight is recorded and dropped.
            if (tick && state_q != S_WAIT_TICK) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (!fault_q) begin
                        state_q     <= S_WAIT_TICK;
                        pid_clear_q <= 1'b0;
                    end
                end
                S_WAIT_TICK: begin
                    if (tick) begin
                        state_q    <= S_REQ;
                        meas_req_q <= 1'b1;
                        tmo_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                S_REQ: begin
                    // An ack on the terminal timeout cycle still counts as a good measurement.
                    if (meas_ack) begin
                        y_q          <= meas_data;
                        referencia_q <= ref_in;
                        meas_req_q   <= 1'b0;
                        enable_q     <= 1'b1;
                        state_q      <= S_STEP;
                    end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                        fault_q     <= 1'b1;
                        duty_q      <= '0;
                        meas_req_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        pid_clear_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                S_STEP: begin
                    settle_cnt_q <= '0;
                    state_q      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt_q == SW'(SETTLE - 1)) begin
                        state_q <= S_UPDATE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                S_UPDATE: begin
                    duty_q       <= duty_d;
                    duty_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= S_WAIT_TICK;
                end
                default: begin
                    state_q     <= S_IDLE;
                    meas_req_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    pid_clear_q <= 1'b1;
                end
            endcase
        end
    end

    assign meas_req   = meas_req_q;
    assign enable     = enable_q;
    assign pid_clear  = pid_clear_q;
    assign duty_valid = duty_valid_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign overrun    = overrun_q;
    assign duty       = duty_q;
    assign referencia = referencia_q;
    assign y          = y_q;

endmodule
